load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of WAIT cycles allowed without mem_ack before the access is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port rd_en, input, 1, load request from the memory stage.
REQ-005 SHALL have port wr_en, input, 1, store request from the memory stage.
REQ-006 SHALL have port funct3, input, 3, access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port addr, input, 32, byte address (ALU result).
REQ-008 SHALL have port store_data, input, 32, rs2 value.
REQ-009 SHALL have port stall, output, 1, holds the pipeline.
REQ-010 SHALL have port data_memory_output, output, 32, extended load result for the writeback select.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1, one-cycle error pulse, asserted together with done.
REQ-013 SHALL have memory-side ports:
- mem_req, output, 1
- mem_we, output, 1
- mem_addr, output, 32
- mem_wdata, output, 32
- mem_be, output, 4
- mem_rdata, input, 32
- mem_ack, input, 1

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-015 In IDLE, with rd_en or wr_en high, the request SHALL be accepted: addr, funct3, store_data and direction are latched.
- Legal request: next state is WAIT.
- Illegal request: next state is DONE with the error flag set.
REQ-016 A request SHALL be illegal if any of these hold:
- rd_en and wr_en are both high.
- funct3 is not a legal load code; for stores, only 000, 001 and 010 are legal.
- H or HU access with addr[0]=1.
- W access with addr[1:0]!=00.
REQ-017 stall SHALL be asserted in either case:
- state is WAIT;
- state is IDLE and (rd_en|wr_en) is high.
stall SHALL be 0 in DONE and in IDLE with no request.
REQ-018 In WAIT, mem_req SHALL be 1. mem_we, mem_addr, mem_wdata and mem_be SHALL be driven from latched values and SHALL remain stable until mem_ack is sampled high.
REQ-019 mem_addr SHALL be {latched addr[31:2], 2'b00}.
REQ-020 Store byte steering SHALL be:
- SB: mem_be = 4'b0001 << addr[1:0]; mem_wdata = {4{store_data[7:0]}}.
- SH: mem_be = addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{store_data[15:0]}}.
- SW: mem_be = 4'b1111; mem_wdata = store_data.
REQ-021 Loads SHALL drive mem_we=0 and mem_be=4'b1111.
REQ-022 On mem_ack in WAIT, next state SHALL be DONE. For loads, data_memory_output SHALL register the extracted field:
- LB: byte addr[1:0] of mem_rdata, sign-extended.
- LBU: same byte, zero-extended.
- LH: halfword addr[1], sign-extended.
- LHU: same halfword, zero-extended.
- LW: full word.
REQ-023 Stores SHALL leave data_memory_output unchanged.
REQ-024 A WAIT cycle counter SHALL clear on entry to WAIT. If it reaches TIMEOUT without mem_ack, next state SHALL be DONE with the error flag set, mem_req SHALL drop, and data_memory_output SHALL be unchanged.
REQ-025 In DONE, done SHALL be 1 and err SHALL equal the latched error flag. DONE SHALL always go to IDLE on the next cycle; rd_en/wr_en SHALL be ignored in DONE.
REQ-026 Outside WAIT, mem_req SHALL be 0 and mem_ack SHALL be ignored.
REQ-027 Latency SHALL be 2 + N cycles, request cycle to done cycle inclusive of done, where N is the number of WAIT cycles (N≥1). An illegal request SHALL take 2 cycles.

Reset
REQ-028 While rst_n=0, outputs SHALL be:
- state IDLE
- mem_req=0, mem_we=0
- mem_addr=0, mem_wdata=0, mem_be=0
- data_memory_output=0
- done=0, err=0
- counter=0
stall follows REQ-017 from rd_en/wr_en.
REQ-029 Reset asserted in WAIT SHALL drop mem_req immediately (asynchronously). After reset release, no done pulse SHALL occur for the aborted access.

Verification
REQ-030 LW addr=0x100, mem_ack on first WAIT cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111; stall high 2 cycles; DONE: data_memory_output=0xDEADBEEF, done=1, err=0.
REQ-031 LB addr=0x103, mem_rdata=0x80112233 -> data_memory_output=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x00008011.
REQ-032 SB addr=0x201 data=0x000000AB -> mem_we=1, mem_addr=0x200, mem_be=0010, mem_wdata=0xABABABAB; SH addr=0x202 data=0x1234 -> mem_be=1100, mem_wdata=0x12341234.
REQ-033 LW addr=0x102 -> no mem_req ever; DONE next cycle with done=1, err=1; data_memory_output unchanged.
REQ-034 LW with mem_ack held low, TIMEOUT=16 -> mem_req high 16 cycles then low; done=1, err=1; stall released in DONE.
REQ-035 rst_n pulsed low mid-WAIT -> mem_req=0 immediately, data_memory_output=0; no done after release; next LW completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: request/address/data out, read data and ack back.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory-stage access, drives a word-aligned memory
// request with byte enables, extracts/extends load data, and aborts on timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_en,
    input  logic                      wr_en,
    input  logic [2:0]                funct3,
    input  logic [31:0]               addr,
    input  logic [31:0]               store_data,
    output logic                      stall,
    output logic [31:0]               data_memory_output,
    output logic                      done,
    output logic                      err,
    load_store_unit_if.master         mem
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             err_next;

    logic             req_c;
    logic             code_ok_c;
    logic             misalign_c;
    logic             req_legal_c;
    logic             accept_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;

    logic [1:0]       lat_off;
    logic [2:0]       lat_funct3;
    logic             lat_load;

    logic [7:0]       rbyte_c;
    logic [15:0]      rhalf_c;
    logic [31:0]      load_data_c;

    // Pipeline hold: busy in WAIT, or a request is being presented in IDLE.
    always_comb begin
        req_c = rd_en | wr_en;
        stall = (state == WAIT) || ((state == IDLE) && req_c);
    end

    // Request legality: direction conflict, funct3 code, natural alignment.
    always_comb begin
        if (wr_en) begin
            code_ok_c = funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            code_ok_c = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        misalign_c  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        req_legal_c = !(rd_en && wr_en) && code_ok_c && !misalign_c;
        accept_c    = (state == IDLE) && req_c && req_legal_c;
    end

    // Store byte-lane steering; loads always read the full word.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = store_data;
        if (wr_en) begin
            case (funct3[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << addr[1:0];
                    wdata_c = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be_c    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{store_data[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = store_data;
                end
            endcase
        end
    end

    // Load field extraction and sign/zero extension from the latched offset/type.
    always_comb begin
        case (lat_off)
            2'd0:    rbyte_c = mem.mem_rdata[7:0];
            2'd1:    rbyte_c = mem.mem_rdata[15:8];
            2'd2:    rbyte_c = mem.mem_rdata[23:16];
            default: rbyte_c = mem.mem_rdata[31:24];
        endcase
        rhalf_c = lat_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (lat_funct3)
            3'b000:  load_data_c = {{24{rbyte_c[7]}}, rbyte_c};
            3'b100:  load_data_c = {24'h000000, rbyte_c};
            3'b001:  load_data_c = {{16{rhalf_c[15]}}, rhalf_c};
            3'b101:  load_data_c = {16'h0000, rhalf_c};
            default: load_data_c = mem.mem_rdata;
        endcase
    end

    // Next-state logic with WAIT cycle counter and error flag.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (req_c) begin
                    if (req_legal_c) begin
                        state_next = WAIT;
                    end else begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (mem.mem_ack) begin
                    state_next = DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Registered outputs: memory bus, completion pulses, load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.mem_req        <= 1'b0;
            mem.mem_we         <= 1'b0;
            mem.mem_addr       <= '0;
            mem.mem_wdata      <= '0;
            mem.mem_be         <= '0;
            lat_off            <= '0;
            lat_funct3         <= '0;
            lat_load           <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            data_memory_output <= '0;
        end else begin
            mem.mem_req <= (state_next == WAIT);
            done        <= (state_next == DONE);
            err         <= err_next;
            if (accept_c) begin
                mem.mem_we    <= wr_en;
                mem.mem_addr  <= {addr[31:2], 2'b00};
                mem.mem_wdata <= wdata_c;
                mem.mem_be    <= be_c;
                lat_off       <= addr[1:0];
                lat_funct3    <= funct3;
                lat_load      <= rd_en;
            end
            if ((state == WAIT) && mem.mem_ack && lat_load) begin
                data_memory_output <= load_data_c;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, illegal requests, timeout, reset abort.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] data_memory_output;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit_if mem_bus ();

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rd_en              (rd_en),
        .wr_en              (wr_en),
        .funct3             (funct3),
        .addr               (addr),
        .store_data         (store_data),
        .stall              (stall),
        .data_memory_output (data_memory_output),
        .done               (done),
        .err                (err),
        .mem                (mem_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One legal access: n_wait idle WAIT cycles, then ack on the next WAIT cycle.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rdata,
                          input int n_wait, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_dmo);
        rd_en = rd; wr_en = wr; funct3 = f3; addr = a; store_data = sd;
        #1;
        check1({tag, "_stall_req"}, stall, 1'b1);
        check1({tag, "_noreq_idle"}, mem_bus.mem_req, 1'b0);
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < n_wait; i++) begin
            check1({tag, "_req_hold"}, mem_bus.mem_req, 1'b1);
            check1({tag, "_stall_hold"}, stall, 1'b1);
            check32({tag, "_addr_hold"}, mem_bus.mem_addr, exp_addr);
            tick();
        end
        check1({tag, "_req"}, mem_bus.mem_req, 1'b1);
        check1({tag, "_stall_wait"}, stall, 1'b1);
        check1({tag, "_we"}, mem_bus.mem_we, wr);
        check32({tag, "_addr"}, mem_bus.mem_addr, exp_addr);
        check32({tag, "_be"}, {28'h0, mem_bus.mem_be}, {28'h0, exp_be});
        if (wr) check32({tag, "_wdata"}, mem_bus.mem_wdata, exp_wdata);
        mem_bus.mem_rdata = rdata;
        mem_bus.mem_ack   = 1'b1;
        tick();
        mem_bus.mem_ack   = 1'b0;
        check1({tag, "_done"}, done, 1'b1);
        check1({tag, "_err"}, err, 1'b0);
        check1({tag, "_stall_done"}, stall, 1'b0);
        check1({tag, "_req_done"}, mem_bus.mem_req, 1'b0);
        check32({tag, "_dmo"}, data_memory_output, exp_dmo);
        tick();
        check1({tag, "_done_clr"}, done, 1'b0);
    endtask

    // Request rejected in IDLE: DONE with err next cycle, no memory request.
    task automatic illegal(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp_dmo);
        rd_en = rd; wr_en = wr; funct3 = f3; addr = a; store_data = 32'h5555_5555;
        #1;
        check1({tag, "_stall_req"}, stall, 1'b1);
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        check1({tag, "_done"}, done, 1'b1);
        check1({tag, "_err"}, err, 1'b1);
        check1({tag, "_noreq"}, mem_bus.mem_req, 1'b0);
        check1({tag, "_stall_done"}, stall, 1'b0);
        check32({tag, "_dmo"}, data_memory_output, exp_dmo);
        tick();
        check1({tag, "_done_clr"}, done, 1'b0);
        check1({tag, "_err_clr"}, err, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        rd_en = 1'b0; wr_en = 1'b0; funct3 = 3'b000; addr = '0; store_data = '0;
        mem_bus.mem_rdata = '0;
        mem_bus.mem_ack   = 1'b0;

        // Reset values
        #2;
        check1("rst_req", mem_bus.mem_req, 1'b0);
        check1("rst_we", mem_bus.mem_we, 1'b0);
        check32("rst_addr", mem_bus.mem_addr, 32'h0);
        check32("rst_wdata", mem_bus.mem_wdata, 32'h0);
        check32("rst_be", {28'h0, mem_bus.mem_be}, 32'h0);
        check32("rst_dmo", data_memory_output, 32'h0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_stall_idle", stall, 1'b0);
        rd_en = 1'b1;
        #1;
        check1("rst_stall_req", stall, 1'b1);
        rd_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Loads with field extraction
        access("lw",  1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF);
        access("lb",  1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 32'h100, 4'hF, 32'h0, 32'hFFFFFF80);
        access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 32'h100, 4'hF, 32'h0, 32'h00000080);
        access("lhu", 1, 0, 3'b101, 32'h102, 32'h0, 32'h80112233, 2, 32'h100, 4'hF, 32'h0, 32'h00008011);
        access("lh",  1, 0, 3'b001, 32'h102, 32'h0, 32'h80112233, 0, 32'h100, 4'hF, 32'h0, 32'hFFFF8011);
        access("lb0", 1, 0, 3'b000, 32'h100, 32'h0, 32'h80112233, 0, 32'h100, 4'hF, 32'h0, 32'h00000033);

        // Stores: lane steering, load result untouched
        access("sb", 0, 1, 3'b000, 32'h201, 32'h000000AB, 32'hFFFFFFFF, 0, 32'h200, 4'b0010, 32'hABABABAB, 32'h00000033);
        access("sh", 0, 1, 3'b001, 32'h202, 32'h00001234, 32'hFFFFFFFF, 1, 32'h200, 4'b1100, 32'h12341234, 32'h00000033);
        access("sw", 0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 32'h204, 4'b1111, 32'hCAFEF00D, 32'h00000033);

        // Illegal requests
        illegal("lw_mis",  1, 0, 3'b010, 32'h102, 32'h00000033);
        illegal("lh_mis",  1, 0, 3'b001, 32'h101, 32'h00000033);
        illegal("st_bu",   0, 1, 3'b100, 32'h200, 32'h00000033);
        illegal("ld_f3",   1, 0, 3'b011, 32'h200, 32'h00000033);
        illegal("both",    1, 1, 3'b010, 32'h200, 32'h00000033);

        // Timeout: mem_ack held low for the whole WAIT window
        rd_en = 1'b1; funct3 = 3'b010; addr = 32'h300;
        tick();
        rd_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check1("to_req_high", mem_bus.mem_req, 1'b1);
            check32("to_addr", mem_bus.mem_addr, 32'h300);
            tick();
        end
        check1("to_req_low", mem_bus.mem_req, 1'b0);
        check1("to_done", done, 1'b1);
        check1("to_err", err, 1'b1);
        check1("to_stall", stall, 1'b0);
        check32("to_dmo", data_memory_output, 32'h00000033);
        mem_bus.mem_rdata = 32'h11111111;
        mem_bus.mem_ack   = 1'b1;
        tick();
        mem_bus.mem_ack   = 1'b0;
        check1("to_idle_done", done, 1'b0);
        check1("to_idle_req", mem_bus.mem_req, 1'b0);
        check32("to_idle_dmo", data_memory_output, 32'h00000033);

        // Reset in the middle of WAIT
        rd_en = 1'b1; funct3 = 3'b010; addr = 32'h400;
        tick();
        rd_en = 1'b0;
        check1("mr_req_before", mem_bus.mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check1("mr_req_async", mem_bus.mem_req, 1'b0);
        check32("mr_dmo", data_memory_output, 32'h0);
        check1("mr_stall", stall, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("mr_no_done", done, 1'b0);
            check1("mr_no_req", mem_bus.mem_req, 1'b0);
        end
        access("lw_after", 1, 0, 3'b010, 32'h100, 32'h0, 32'h0BADF00D, 0, 32'h100, 4'hF, 32'h0, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
